fir_out_mem_reader: RTL and testbench

- Drains the FIR filter's 26-bit output sample memory (direct or transposed instance) after a run completes.
- Issues sequential synchronous reads and buffers the returned samples in a 2-entry FIFO.
- Presents the samples as a valid/ready stream to downstream logic: DMA, UART dump or on-chip checker.
- It is the read-side counterpart of the filter's output-memory writer, in the same single clock domain.

---
 rtl/fir_out_mem_reader.sv | 108 ++++++++++
 tb/tb_fir_out_mem_reader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fir_out_mem_reader.sv
// fir_out_mem_reader: drains the FIR output sample memory into a valid/ready stream through a 2-entry FIFO.
// Optional golden-sample checker enabled by defining FIR_OUT_CHECK_EN.
module fir_out_mem_reader #(
    parameter int DATA_W = 26,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef FIR_OUT_CHECK_EN
    input  logic [DATA_W-1:0] gold_data,
    output logic [ADDR_W:0]   err_cnt,
    output logic              mismatch,
`endif
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] rd_ptr, fl_idx;
    logic              inflight, wp, rp, pop, accept;
    logic [1:0]        count;
    logic [2:0]        occ;
    logic [DATA_W-1:0] f_data [2];
    logic [ADDR_W-1:0] f_idx [2];

    assign accept    = state == IDLE && start;
    assign out_valid = count != 2'd0;
    assign pop       = out_valid && out_ready;
    assign out_data  = f_data[rp];
    assign out_index = f_idx[rp];
    assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign mem_addr  = mem_rd_en ? rd_ptr : '0;
    assign busy      = state == READ || state == DRAIN;
    assign done      = state == DONE;

    // Next state and read issue; a read goes out only when the FIFO is guaranteed room for its data.
    always_comb begin
        state_nx  = state;
        mem_rd_en = 1'b0;
        case (state)
            IDLE:    state_nx = start ? READ : IDLE;
            READ: begin
                mem_rd_en = occ < 3'd2;
                state_nx  = (mem_rd_en && rd_ptr == LAST) ? DRAIN : READ;
            end
            DRAIN:   state_nx = (count == 2'd0 && !inflight) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Read pointer and tracking of the one read whose data returns next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            fl_idx   <= '0;
            inflight <= 1'b0;
        end else begin
            rd_ptr   <= accept ? '0 : mem_rd_en ? rd_ptr + 1'b1 : rd_ptr;
            fl_idx   <= mem_rd_en ? rd_ptr : fl_idx;
            inflight <= mem_rd_en;
        end
    end

    // Two-entry FIFO; a returning read always pushes, and push with pop on a full FIFO keeps it full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_data <= '{default: '0};
            f_idx  <= '{default: '0};
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (inflight) begin
                f_data[wp] <= mem_rd_data;
                f_idx[wp]  <= fl_idx;
                wp         <= ~wp;
            end
            rp    <= pop ? ~rp : rp;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

`ifdef FIR_OUT_CHECK_EN
    assign mismatch = pop && out_data != gold_data;

    // Saturating mismatch counter, cleared when a new drain is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_cnt <= '0;
        else        err_cnt <= accept ? '0 : (mismatch && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
    end
`endif
endmodule

// File: tb/tb_fir_out_mem_reader.sv
// tb_fir_out_mem_reader: directed bench for fir_out_mem_reader against a preloaded synchronous-read memory.
module tb_fir_out_mem_reader;
    localparam int DW = 26;
    localparam int AW = 8;
    localparam int D  = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, mem_rd_en, out_valid;
    logic [AW-1:0] mem_addr, out_index;
    logic [DW-1:0] mem_rd_data, out_data;
    logic [DW-1:0] mem [D];
    int            n_chk = 0;
    int            n_fail = 0;
`ifdef FIR_OUT_CHECK_EN
    logic [DW-1:0] gold_data;
    logic [AW:0]   err_cnt;
    logic          mismatch;
    assign gold_data = mem[out_index] + ((out_index == 8'd7 || out_index == 8'd200) ? 26'd1 : 26'd0);
`endif

    fir_out_mem_reader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef FIR_OUT_CHECK_EN
        .gold_data(gold_data), .err_cnt(err_cnt), .mismatch(mismatch),
`endif
        .out_data(out_data), .out_index(out_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: ready=1, 1: ready toggles, 2: ready low 20 cycles, 3: reset at sample 100, 4: start again at sample 50
    task automatic run(input int mode, output int cycles, output int n_hs, output int n_done);
        int            issued = 0;
        int            cyc = 0;
        logic          stall = 1'b0;
        logic          poked = 1'b0;
        logic          p;
        logic [DW-1:0] pd = '0;
        logic [AW-1:0] pi = '0;
        n_hs = 0;
        n_done = 0;
        cycles = -1;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 1);
`ifdef FIR_OUT_CHECK_EN
        chk("err_cnt_cleared", {23'd0, err_cnt}, 0);
`endif
        while (cyc < 3000) begin
            if (mode == 2 && cyc == 20) begin
                chk("reads_while_blocked", issued, 2);
                chk("valid_while_blocked", {31'd0, out_valid}, 1);
                chk("index_while_blocked", {24'd0, out_index}, 0);
            end
            if (mode == 3 && n_hs == 100) begin
                reset = 1'b0;
                #1;
                chk("abort_busy", {31'd0, busy}, 0);
                chk("abort_done", {31'd0, done}, 0);
                chk("abort_rd_en", {31'd0, mem_rd_en}, 0);
                chk("abort_valid", {31'd0, out_valid}, 0);
                chk("abort_addr", {24'd0, mem_addr}, 0);
                chk("abort_data", {6'd0, out_data}, 0);
                chk("abort_index", {24'd0, out_index}, 0);
                reset = 1'b1;
                break;
            end
            if (mode == 1)      out_ready = cyc % 2 == 0;
            else if (mode == 2) out_ready = cyc >= 20;
            else                out_ready = 1'b1;
            start = mode == 4 && n_hs == 50 && !poked;
            if (start) poked = 1'b1;
            #1;
            p = out_valid && out_ready;
            if (stall) begin
                chk("hold_valid", {31'd0, out_valid}, 1);
                chk("hold_data", {6'd0, out_data}, {6'd0, pd});
                chk("hold_index", {24'd0, out_index}, {24'd0, pi});
            end
            if (mem_rd_en) begin
                chk("rd_addr", {24'd0, mem_addr}, issued);
                chk("rd_room", {31'd0, (issued - n_hs - int'(p)) < 2}, 1);
                issued++;
            end
            if (p) begin
                chk("out_index", {24'd0, out_index}, n_hs);
                chk("out_data", {6'd0, out_data}, n_hs * 3);
`ifdef FIR_OUT_CHECK_EN
                chk("mismatch", {31'd0, mismatch}, {31'd0, n_hs == 7 || n_hs == 200});
`endif
                n_hs++;
            end
            stall = out_valid && !out_ready;
            pd = out_data;
            pi = out_index;
            if (done) begin
                n_done++;
                cycles = cyc;
                break;
            end
            @(posedge clk);
            #1 cyc++;
        end
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 chk("done_single", {31'd0, done}, 0);
        end
        chk("idle_busy", {31'd0, busy}, 0);
`ifdef FIR_OUT_CHECK_EN
        if (n_hs == D) chk("err_cnt_final", {23'd0, err_cnt}, 2);
`endif
    endtask

    initial begin
        int cycles, n_hs, n_done;
        for (int i = 0; i < D; i++) mem[i] = DW'(i * 3);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 0);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_addr", {24'd0, mem_addr}, 0);
        chk("rst_data", {6'd0, out_data}, 0);
        chk("rst_index", {24'd0, out_index}, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run(0, cycles, n_hs, n_done);
        chk("full_cycles", cycles, 259);
        chk("full_samples", n_hs, 256);
        chk("full_done", n_done, 1);
        run(1, cycles, n_hs, n_done);
        chk("toggle_samples", n_hs, 256);
        chk("toggle_done", n_done, 1);
        run(2, cycles, n_hs, n_done);
        chk("blocked_samples", n_hs, 256);
        chk("blocked_done", n_done, 1);
        run(3, cycles, n_hs, n_done);
        chk("abort_samples", n_hs, 100);
        chk("abort_no_done", n_done, 0);
        run(0, cycles, n_hs, n_done);
        chk("rerun_cycles", cycles, 259);
        chk("rerun_samples", n_hs, 256);
        chk("rerun_done", n_done, 1);
        run(4, cycles, n_hs, n_done);
        chk("restart_samples", n_hs, 256);
        chk("restart_done", n_done, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
